// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with bubble/stall/flush handling and a debug
// run/step/stop-on-EOP controller. All state updates on the falling clock edge.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 77,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              debugReset,
  input  logic              debugEnable,
  input  logic              stepReq,
  input  logic              stopOnEop,
  input  logic              stall,
  input  logic              flush,
  input  logic              validIn,
  input  logic              eopIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  output logic [DATA_W-1:0] dataOut,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic              validOut,
  output logic              eopOut,
  output logic              advance,
  output logic              halted,
  output logic              eopHalted,
  output logic [CNT_W-1:0]  advCount
);

  typedef enum logic [1:0] {StHalt, StRun, StStep, StEopHalt} state_t;

  state_t              stateQ, stateD;
  logic [DATA_W-1:0]   dataQ;
  logic [CTRL_W-1:0]   ctrlQ;
  logic                validQ, eopQ, advanceQ;
  logic [CNT_W-1:0]    advCountQ;

  logic canRun, doAdvance, capEop, stopHit;

  always_comb begin
    canRun    = (stateQ == StRun) || (stateQ == StStep);
    // flush overrides stall and always yields an advance
    doAdvance = canRun && (flush || !stall);
    capEop    = eopIn && !flush;
    stopHit   = doAdvance && capEop && stopOnEop;
    stateD    = stateQ;
    unique case (stateQ)
      StHalt: begin
        if (debugEnable)  stateD = StRun;
        else if (stepReq) stateD = StStep;
      end
      StRun: begin
        if (stopHit)           stateD = StEopHalt;
        else if (!debugEnable) stateD = StHalt;
      end
      StStep: begin
        if (stopHit)        stateD = StEopHalt;
        else if (doAdvance) stateD = StHalt;
      end
      StEopHalt: stateD = StEopHalt;
      default:   stateD = StHalt;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stateQ    <= StHalt;
      dataQ     <= '0;
      ctrlQ     <= '0;
      validQ    <= 1'b0;
      eopQ      <= 1'b0;
      advanceQ  <= 1'b0;
      advCountQ <= '0;
    end else if (debugReset) begin
      stateQ    <= StHalt;
      dataQ     <= '0;
      ctrlQ     <= '0;
      validQ    <= 1'b0;
      eopQ      <= 1'b0;
      advanceQ  <= 1'b0;
      advCountQ <= '0;
    end else begin
      stateQ   <= stateD;
      advanceQ <= doAdvance;
      if (doAdvance) begin
        dataQ  <= dataIn;
        ctrlQ  <= flush ? '0 : ctrlIn;
        validQ <= validIn && !flush;
        eopQ   <= capEop;
        if (advCountQ != '1) advCountQ <= advCountQ + CNT_W'(1);
      end
    end
  end

  assign dataOut   = dataQ;
  assign ctrlOut   = ctrlQ;
  assign validOut  = validQ;
  assign eopOut    = eopQ;
  assign advance   = advanceQ;
  assign advCount  = advCountQ;
  assign halted    = (stateQ == StHalt) || (stateQ == StEopHalt);
  assign eopHalted = (stateQ == StEopHalt);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus queues expected captures, a
// monitor compares them whenever the stage reports an advance.
module tb_pipe_stage_reg;

  logic        clock = 1'b0;
  logic        reset, debugReset, debugEnable, stepReq, stopOnEop, stall, flush;
  logic        validIn, eopIn;
  logic [76:0] dataIn;
  logic [7:0]  ctrlIn;
  logic [76:0] dataOut;
  logic [7:0]  ctrlOut;
  logic        validOut, eopOut, advance, halted, eopHalted;
  logic [15:0] advCount;

  logic [76:0] dataOut2;
  logic [7:0]  ctrlOut2;
  logic        validOut2, eopOut2, advance2, halted2, eopHalted2;
  logic [1:0]  advCount2;

  typedef struct packed {
    logic [76:0] d;
    logic [7:0]  c;
    logic        v;
    logic        e;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  pipe_stage_reg dut (
    .clock(clock), .reset(reset), .debugReset(debugReset), .debugEnable(debugEnable),
    .stepReq(stepReq), .stopOnEop(stopOnEop), .stall(stall), .flush(flush),
    .validIn(validIn), .eopIn(eopIn), .dataIn(dataIn), .ctrlIn(ctrlIn),
    .dataOut(dataOut), .ctrlOut(ctrlOut), .validOut(validOut), .eopOut(eopOut),
    .advance(advance), .halted(halted), .eopHalted(eopHalted), .advCount(advCount)
  );

  // Narrow-counter instance sharing all inputs, used for saturation.
  pipe_stage_reg #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .debugReset(debugReset), .debugEnable(debugEnable),
    .stepReq(stepReq), .stopOnEop(stopOnEop), .stall(stall), .flush(flush),
    .validIn(validIn), .eopIn(eopIn), .dataIn(dataIn), .ctrlIn(ctrlIn),
    .dataOut(dataOut2), .ctrlOut(ctrlOut2), .validOut(validOut2), .eopOut(eopOut2),
    .advance(advance2), .halted(halted2), .eopHalted(eopHalted2), .advCount(advCount2)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [76:0] d, input logic [7:0] c, input logic v, input logic e);
    exp_t x;
    x.d = d; x.c = c; x.v = v; x.e = e;
    expQ.push_back(x);
  endtask

  // Monitor: sampled on the rising edge, half a cycle away from updates.
  always @(posedge clock) begin
    if (!reset && advance) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL capture: unexpected advance with data 0x%0h", dataOut);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if ({dataOut, ctrlOut, validOut, eopOut} !== e) begin
          failures++;
          $display("FAIL capture: got d=0x%0h c=0x%0h v=%0b e=%0b expected d=0x%0h c=0x%0h v=%0b e=%0b",
                   dataOut, ctrlOut, validOut, eopOut, e.d, e.c, e.v, e.e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; debugReset = 1'b0; debugEnable = 1'b0; stepReq = 1'b0;
    stopOnEop = 1'b0; stall = 1'b0; flush = 1'b0; validIn = 1'b0; eopIn = 1'b0;
    dataIn = '0; ctrlIn = '0;
    #7 reset = 1'b0;
    chk("rst_data", dataOut, 0);
    chk("rst_flags", {ctrlOut, validOut, eopOut, advance, eopHalted}, 0);
    chk("rst_halted", halted, 1);
    chk("rst_count", advCount, 0);

    // Idle while halted: nothing captured.
    dataIn = 77'h1234; ctrlIn = 8'h5A; validIn = 1'b1;
    repeat (5) tick();
    chk("idle_data", dataOut, 0);
    chk("idle_count", advCount, 0);

    // Free run: first edge is HALT->RUN only.
    debugEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataIn = 77'h100 + 77'(i); ctrlIn = 8'(i);
      if (i > 0) push(dataIn, ctrlIn, 1'b1, 1'b0);
      tick();
      if (i == 0) chk("run_first_edge_no_capture", dataOut, 0);
    end
    chk("run_count", advCount, 9);
    chk("run_data", dataOut, 77'h109);
    chk("run_halted", halted, 0);
    chk("sat_count", advCount2, 3);

    // Dropping debugEnable: the RUN edge still captures, then halts.
    debugEnable = 1'b0; dataIn = 77'h200; ctrlIn = 8'h20;
    push(dataIn, ctrlIn, 1'b1, 1'b0);
    tick();
    chk("stop_halted", halted, 1);
    chk("stop_count", advCount, 10);

    // Single step held off by three stalled edges; a repeat request is ignored.
    stall = 1'b1; stepReq = 1'b1; dataIn = 77'h300; ctrlIn = 8'h30;
    tick();
    chk("step_entered", halted, 0);
    for (int i = 0; i < 3; i++) begin
      stepReq = (i == 0);
      tick();
    end
    chk("step_stall_data", dataOut, 77'h200);
    chk("step_stall_count", advCount, 10);
    stall = 1'b0; stepReq = 1'b0;
    push(dataIn, ctrlIn, 1'b1, 1'b0);
    tick();
    chk("step_halted", halted, 1);
    chk("step_count", advCount, 11);
    dataIn = 77'h301;
    tick();
    chk("step_once_data", dataOut, 77'h300);
    chk("step_once_count", advCount, 11);

    // Flush beats stall.
    debugEnable = 1'b1;
    tick();
    flush = 1'b1; stall = 1'b1; dataIn = 77'h400; ctrlIn = 8'hFF; validIn = 1'b1; eopIn = 1'b1;
    push(dataIn, 8'h00, 1'b0, 1'b0);
    tick();
    chk("flush_ctrl", ctrlOut, 0);
    chk("flush_valid", validOut, 0);
    chk("flush_data", dataOut, 77'h400);
    chk("flush_count", advCount, 12);
    flush = 1'b0; stall = 1'b0; eopIn = 1'b0;

    // Stop on EOP at the 4th capture.
    stopOnEop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dataIn = 77'h500 + 77'(k); ctrlIn = 8'h50 + 8'(k); eopIn = (k == 3);
      push(dataIn, ctrlIn, 1'b1, eopIn);
      tick();
    end
    eopIn = 1'b0;
    chk("eop_out", eopOut, 1);
    chk("eop_halted", {eopHalted, halted}, 2'b11);
    chk("eop_count", advCount, 16);
    dataIn = 77'h5FF;
    debugEnable = 1'b0; tick();
    debugEnable = 1'b1; tick();
    tick();
    chk("eop_hold_data", dataOut, 77'h503);
    chk("eop_hold_state", eopHalted, 1);
    chk("eop_hold_count", advCount, 16);
    debugEnable = 1'b0; debugReset = 1'b1;
    tick();
    debugReset = 1'b0;
    chk("dbgrst_outputs", {dataOut, ctrlOut, validOut, eopOut, advance, eopHalted}, 0);
    chk("dbgrst_halted", halted, 1);
    chk("dbgrst_count", advCount, 0);
    chk("dbgrst_count2", advCount2, 0);

    // Asynchronous reset between edges.
    stopOnEop = 1'b0; debugEnable = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      dataIn = 77'h600 + 77'(k); ctrlIn = 8'h60;
      push(dataIn, ctrlIn, 1'b1, 1'b0);
      tick();
    end
    chk("pre_areset_data", dataOut, 77'h601);
    debugEnable = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("areset_outputs", {dataOut, ctrlOut, validOut, eopOut, advance}, 0);
    chk("areset_count", advCount, 0);
    chk("areset_halted", halted, 1);
    reset = 1'b0;
    tick();
    tick();
    chk("scoreboard_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
